cv_mem_arb: RTL and testbench
=============================

CV_MEM_ARB -- requirements
Module: cv_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, external memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles, used only under CV_MEM_ARB_WDOG_EN.
REQ-003 SHALL have clk_i  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have reset_n_i  in  1  synchronous, active-low reset.
REQ-005 SHALL have cpu_a_i in 16 (Z80 address); cpu_d_i in 8 (write data); cpu_d_o out 8 (registered read data).
REQ-006 SHALL have cpu_rd_n_i in 1, cpu_wr_n_i in 1 (Z80 strobes); cpu_wait_n_o out 1 (Z80 WAIT, active low).
REQ-007 SHALL have bios_rom_ce_n_i, ram_ce_n_i, upper_ram_ce_n_i in 1 each; cart_ce_n_i in 4 (bit0=80, 1=A0, 2=C0, 3=E0); cart_page_i in 6. These are the address-decoder region selects.
REQ-008 SHALL have ldr_wr_i in 1 (loader write pulse), ldr_addr_i in ADDR_W, ldr_d_i in 8, ldr_busy_o out 1.
REQ-009 SHALL have mem_req_o out 1, mem_we_o out 1, mem_addr_o out ADDR_W, mem_d_o out 8, mem_d_i in 8, mem_ack_i in 1 (single-cycle pulse).
REQ-010 SHALL have err_o  out  1  sticky watchdog error flag.

Function
REQ-011 A CPU strobe SHALL be any region CE low AND (rd_n low OR wr_n low); a CPU request SHALL be pending when the strobe is high and cpu_done is clear.
REQ-012 cpu_wait_n_o SHALL be combinationally low while a CPU request is pending.
REQ-013 cpu_done SHALL set on completion and clear on the first cycle the strobe is low, giving exactly one access per Z80 bus cycle.
REQ-014 Address map: BIOS=0x000000|a[12:0]; RAM=0x100000|a[14:0]; upper RAM=0x108000|a[14:0]; cart=0x200000|{cart_page_i,a[13:0]}.
REQ-015 CPU writes to BIOS or cart SHALL complete in 1 cycle with no mem_req_o.
REQ-016 The loader SHALL use a 1-entry buffer: ldr_wr_i captures addr/data and sets ldr_busy_o; the entry clears on mem ack. ldr_wr_i while busy SHALL be dropped.
REQ-017 FSM states: IDLE, CPU_ACC, LDR_ACC.
REQ-018 IDLE SHALL grant a single requester; with both pending it SHALL grant the one not granted last (round-robin, last_grant reset=CPU, so the loader wins the first tie).
REQ-019 In CPU_ACC/LDR_ACC, mem_req_o and the address/data/we outputs SHALL be registered and held stable until mem_ack_i.
REQ-020 On ack the FSM SHALL return to IDLE; a CPU read SHALL latch mem_d_i into cpu_d_o on that edge, and wait_n SHALL release the next cycle.
REQ-021 mem_ack_i SHALL be ignored in IDLE.
REQ-022 Minimum CPU read latency: request to wait_n high = 2 cycles plus memory ack delay.

Reset
REQ-023 Reset SHALL drive: FSM=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_d_o=0, cpu_d_o=0xFF, cpu_done=0, loader buffer empty (ldr_busy_o=0), err_o=0, watchdog counter=0.
REQ-024 Reset asserted mid-access SHALL abort the access; a late ack SHALL be ignored.

Configuration
REQ-025 With CV_MEM_ARB_WDOG_EN defined, an 8-bit counter SHALL run in CPU_ACC/LDR_ACC. When it reaches TIMEOUT with no ack: FSM→IDLE, err_o set, a CPU read returns 0xFF with cpu_done set, a loader entry is discarded.
REQ-026 Without CV_MEM_ARB_WDOG_EN, there SHALL be no counter, err_o SHALL be tied 0, and the port list SHALL be unchanged.

Structure
REQ-027 Package cv_mem_pkg SHALL hold: FSM state enum, region base constants, region enum.
REQ-028 Sub-module cv_mem_arb_map SHALL be the combinational CE/page→address mapper; everything else stays in cv_mem_arb.

Verification
REQ-029 CPU read 0x0123 with bios CE low, ack 3 cycles after req, mem_d_i=0x5A → mem_addr_o=0x000123, cpu_d_o=0x5A, wait_n low until 1 cycle after ack.
REQ-030 CPU write 0x9000 with cart_ce_n_i[0] low → no mem_req_o, wait_n high after 1 cycle.
REQ-031 cart_ce_n_i[2] low, cart_page_i=0x05, a=0xC010 read → mem_addr_o=0x214010.
REQ-032 Loader write and CPU RAM read (a=0x6000) pending in the same cycle after reset → loader served first, then CPU at 0x106000; second ldr_wr_i while busy is dropped.
REQ-033 CV_MEM_ARB_WDOG_EN, TIMEOUT=255, no ack → after 255 cycles err_o=1, cpu_d_o=0xFF, wait_n high.
REQ-034 Reset pulse during CPU_ACC, then stray ack → FSM IDLE, mem_req_o=0, no cpu_d_o update.

Source files
------------

// File: rtl/cv_mem_pkg.sv
// Shared types and constants for the ColecoVision memory arbiter:
// FSM states, decoded CPU regions and external memory base addresses.
package cv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_LDR_ACC = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_BIOS = 3'd1,
        REG_RAM  = 3'd2,
        REG_URAM = 3'd3,
        REG_CART = 3'd4
    } region_t;

    localparam logic [31:0] BIOS_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h0010_0000;
    localparam logic [31:0] URAM_BASE = 32'h0010_8000;
    localparam logic [31:0] CART_BASE = 32'h0020_0000;

endpackage

// File: rtl/cv_mem_arb_map.sv
// Combinational region decode: turns the active-low region selects, the
// cartridge page and the Z80 address into a region tag and a flat memory address.
module cv_mem_arb_map
    import cv_mem_pkg::*;
#(
    parameter int ADDR_W = 22
) (
    input  logic [15:0]       cpu_a,
    input  logic              bios_rom_ce_n,
    input  logic              ram_ce_n,
    input  logic              upper_ram_ce_n,
    input  logic [3:0]        cart_ce_n,
    input  logic [5:0]        cart_page,
    output region_t           region,
    output logic [ADDR_W-1:0] addr
);

    // a[15] carries no information once a region CE has been decoded
    logic unused_a15;
    assign unused_a15 = cpu_a[15];

    always_comb begin
        region = REG_NONE;
        addr   = '0;
        if (!bios_rom_ce_n) begin
            region = REG_BIOS;
            addr   = ADDR_W'(BIOS_BASE) | ADDR_W'(cpu_a[12:0]);
        end else if (!ram_ce_n) begin
            region = REG_RAM;
            addr   = ADDR_W'(RAM_BASE) | ADDR_W'(cpu_a[14:0]);
        end else if (!upper_ram_ce_n) begin
            region = REG_URAM;
            addr   = ADDR_W'(URAM_BASE) | ADDR_W'(cpu_a[14:0]);
        end else if (cart_ce_n != 4'hF) begin
            region = REG_CART;
            addr   = ADDR_W'(CART_BASE) | ADDR_W'({cart_page, cpu_a[13:0]});
        end
    end

endmodule

// File: rtl/cv_mem_arb.sv
// Arbitrates Z80 bus cycles and a one-entry loader write buffer onto a single
// req/ack memory port. Define CV_MEM_ARB_WDOG_EN to enable the access watchdog.
module cv_mem_arb
    import cv_mem_pkg::*;
#(
    parameter int ADDR_W  = 22,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [15:0]       cpu_a_i,
    input  logic [7:0]        cpu_d_i,
    output logic [7:0]        cpu_d_o,
    input  logic              cpu_rd_n_i,
    input  logic              cpu_wr_n_i,
    output logic              cpu_wait_n_o,
    input  logic              bios_rom_ce_n_i,
    input  logic              ram_ce_n_i,
    input  logic              upper_ram_ce_n_i,
    input  logic [3:0]        cart_ce_n_i,
    input  logic [5:0]        cart_page_i,
    input  logic              ldr_wr_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [7:0]        ldr_d_i,
    output logic              ldr_busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_d_o,
    input  logic [7:0]        mem_d_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    region_t           region;
    logic [ADDR_W-1:0] cpu_addr;
    state_t            state, state_nxt;
    logic              cpu_done, last_ldr;
    logic [ADDR_W-1:0] ldr_addr_q;
    logic [7:0]        ldr_d_q;
    logic              cpu_strobe, cpu_pend, cpu_wr, cpu_ro_wr, cpu_req, ldr_req;
    logic              grant_cpu, grant_ldr, acc_end, wd_expire;

    cv_mem_arb_map #(.ADDR_W(ADDR_W)) u_map (
        .cpu_a          (cpu_a_i),
        .bios_rom_ce_n  (bios_rom_ce_n_i),
        .ram_ce_n       (ram_ce_n_i),
        .upper_ram_ce_n (upper_ram_ce_n_i),
        .cart_ce_n      (cart_ce_n_i),
        .cart_page      (cart_page_i),
        .region         (region),
        .addr           (cpu_addr)
    );

    assign cpu_wr     = !cpu_wr_n_i;
    assign cpu_strobe = (region != REG_NONE) && (!cpu_rd_n_i || !cpu_wr_n_i);
    assign cpu_pend   = cpu_strobe && !cpu_done;
    // Writes into ROM space are swallowed locally and never reach memory
    assign cpu_ro_wr  = cpu_wr && (region == REG_BIOS || region == REG_CART);
    assign cpu_req    = cpu_pend && !cpu_ro_wr;
    assign ldr_req    = ldr_busy_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_cpu)      state_nxt = ST_CPU_ACC;
                else if (grant_ldr) state_nxt = ST_LDR_ACC;
            end
            ST_CPU_ACC, ST_LDR_ACC: begin
                if (acc_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_cpu    = 1'b0;
        grant_ldr    = 1'b0;
        acc_end      = 1'b0;
        cpu_wait_n_o = !cpu_pend;
        case (state)
            ST_IDLE: begin
                if (cpu_req && ldr_req) begin
                    grant_ldr = !last_ldr;
                    grant_cpu = last_ldr;
                end else begin
                    grant_cpu = cpu_req;
                    grant_ldr = ldr_req;
                end
            end
            ST_CPU_ACC, ST_LDR_ACC: acc_end = mem_ack_i || wd_expire;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_d_o    <= '0;
            cpu_d_o    <= 8'hFF;
            cpu_done   <= 1'b0;
            ldr_busy_o <= 1'b0;
            last_ldr   <= 1'b0;
        end else begin
            if (!cpu_strobe)
                cpu_done <= 1'b0;
            else if (cpu_pend && cpu_ro_wr)
                cpu_done <= 1'b1;

            if (ldr_wr_i && !ldr_busy_o)
                ldr_busy_o <= 1'b1;

            if (grant_cpu) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= cpu_wr;
                mem_addr_o <= cpu_addr;
                mem_d_o    <= cpu_d_i;
                last_ldr   <= 1'b0;
            end else if (grant_ldr) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b1;
                mem_addr_o <= ldr_addr_q;
                mem_d_o    <= ldr_d_q;
                last_ldr   <= 1'b1;
            end

            // Completion by ack or watchdog; a timed-out read returns open-bus 0xFF
            if (acc_end) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
                if (state == ST_CPU_ACC) begin
                    cpu_done <= 1'b1;
                    if (!mem_we_o)
                        cpu_d_o <= mem_ack_i ? mem_d_i : 8'hFF;
                end else begin
                    ldr_busy_o <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ldr_wr_i && !ldr_busy_o) begin
            ldr_addr_q <= ldr_addr_i;
            ldr_d_q    <= ldr_d_i;
        end
    end

`ifdef CV_MEM_ARB_WDOG_EN
    logic [7:0] wd_cnt;

    assign wd_expire = (state != ST_IDLE) && !mem_ack_i && (wd_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wd_cnt <= 8'd0;
            err_o  <= 1'b0;
        end else begin
            if (state == ST_IDLE || acc_end)
                wd_cnt <= 8'd0;
            else
                wd_cnt <= wd_cnt + 8'd1;
            if (wd_expire)
                err_o <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign wd_expire      = 1'b0;
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_cv_mem_arb.sv
// Directed bench for cv_mem_arb: region mapping, ROM-write bypass, loader
// round-robin, reset abort and (when enabled) the watchdog.
module tb_cv_mem_arb;

    localparam int ADDR_W = 22;

    logic              clk = 1'b0;
    logic              reset_n_i;
    logic [15:0]       cpu_a_i;
    logic [7:0]        cpu_d_i;
    logic [7:0]        cpu_d_o;
    logic              cpu_rd_n_i, cpu_wr_n_i, cpu_wait_n_o;
    logic              bios_rom_ce_n_i, ram_ce_n_i, upper_ram_ce_n_i;
    logic [3:0]        cart_ce_n_i;
    logic [5:0]        cart_page_i;
    logic              ldr_wr_i;
    logic [ADDR_W-1:0] ldr_addr_i;
    logic [7:0]        ldr_d_i;
    logic              ldr_busy_o;
    logic              mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_d_o, mem_d_i;
    logic              mem_ack_i;
    logic              err_o;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    cv_mem_arb #(.ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .cpu_a_i          (cpu_a_i),
        .cpu_d_i          (cpu_d_i),
        .cpu_d_o          (cpu_d_o),
        .cpu_rd_n_i       (cpu_rd_n_i),
        .cpu_wr_n_i       (cpu_wr_n_i),
        .cpu_wait_n_o     (cpu_wait_n_o),
        .bios_rom_ce_n_i  (bios_rom_ce_n_i),
        .ram_ce_n_i       (ram_ce_n_i),
        .upper_ram_ce_n_i (upper_ram_ce_n_i),
        .cart_ce_n_i      (cart_ce_n_i),
        .cart_page_i      (cart_page_i),
        .ldr_wr_i         (ldr_wr_i),
        .ldr_addr_i       (ldr_addr_i),
        .ldr_d_i          (ldr_d_i),
        .ldr_busy_o       (ldr_busy_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_d_o          (mem_d_o),
        .mem_d_i          (mem_d_i),
        .mem_ack_i        (mem_ack_i),
        .err_o            (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bios_rom_ce_n_i  = 1'b1;
        ram_ce_n_i       = 1'b1;
        upper_ram_ce_n_i = 1'b1;
        cart_ce_n_i      = 4'hF;
        cpu_rd_n_i       = 1'b1;
        cpu_wr_n_i       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: observed no finish required finish");
        $fatal(1);
    end

    initial begin
        reset_n_i   = 1'b0;
        bus_idle();
        cpu_a_i     = 16'h0000;
        cpu_d_i     = 8'h00;
        cart_page_i = 6'h00;
        ldr_wr_i    = 1'b0;
        ldr_addr_i  = '0;
        ldr_d_i     = 8'h00;
        mem_d_i     = 8'h00;
        mem_ack_i   = 1'b0;
        repeat (3) tick();

        chk("rst_req",    32'(mem_req_o),    32'h0);
        chk("rst_we",     32'(mem_we_o),     32'h0);
        chk("rst_addr",   32'(mem_addr_o),   32'h0);
        chk("rst_d",      32'(mem_d_o),      32'h0);
        chk("rst_cpu_d",  32'(cpu_d_o),      32'hFF);
        chk("rst_busy",   32'(ldr_busy_o),   32'h0);
        chk("rst_err",    32'(err_o),        32'h0);
        chk("rst_wait_n", 32'(cpu_wait_n_o), 32'h1);
        reset_n_i = 1'b1;
        tick();

        // BIOS read, ack sampled three cycles after the request appears
        cpu_a_i = 16'h0123; bios_rom_ce_n_i = 1'b0; cpu_rd_n_i = 1'b0;
        #1;
        chk("bios_wait_comb", 32'(cpu_wait_n_o), 32'h0);
        tick();
        chk("bios_req",   32'(mem_req_o),  32'h1);
        chk("bios_addr",  32'(mem_addr_o), 32'h000123);
        chk("bios_we",    32'(mem_we_o),   32'h0);
        tick(); tick();
        chk("bios_req_hold", 32'(mem_req_o), 32'h1);
        mem_ack_i = 1'b1; mem_d_i = 8'h5A;
        #1;
        chk("bios_wait_at_ack", 32'(cpu_wait_n_o), 32'h0);
        tick();
        mem_ack_i = 1'b0;
        chk("bios_rdata",  32'(cpu_d_o),      32'h5A);
        chk("bios_release",32'(cpu_wait_n_o), 32'h1);
        chk("bios_req_off",32'(mem_req_o),    32'h0);
        bus_idle();
        tick();

        // Cartridge write is dropped locally in one cycle
        cpu_a_i = 16'h9000; cart_ce_n_i = 4'b1110; cpu_wr_n_i = 1'b0; cpu_d_i = 8'h77;
        #1;
        chk("cartwr_wait_comb", 32'(cpu_wait_n_o), 32'h0);
        tick();
        chk("cartwr_release", 32'(cpu_wait_n_o), 32'h1);
        chk("cartwr_no_req",  32'(mem_req_o),    32'h0);
        tick();
        chk("cartwr_no_req2", 32'(mem_req_o),    32'h0);
        bus_idle();
        tick();

        // Cartridge read in the C0 window, page 5
        cpu_a_i = 16'hC010; cart_ce_n_i = 4'b1011; cart_page_i = 6'h05; cpu_rd_n_i = 1'b0;
        tick();
        chk("cart_req",  32'(mem_req_o),  32'h1);
        chk("cart_addr", 32'(mem_addr_o), 32'h214010);
        mem_ack_i = 1'b1; mem_d_i = 8'hC3;
        tick();
        mem_ack_i = 1'b0;
        chk("cart_rdata",  32'(cpu_d_o),      32'hC3);
        chk("cart_release",32'(cpu_wait_n_o), 32'h1);
        bus_idle();
        tick();

        // Fresh reset so the loader wins the first tie
        reset_n_i = 1'b0;
        tick(); tick();
        reset_n_i = 1'b1;
        tick();
        ldr_wr_i = 1'b1; ldr_addr_i = 22'h012345; ldr_d_i = 8'hAB;
        tick();
        chk("ldr_busy_set", 32'(ldr_busy_o), 32'h1);
        chk("ldr_no_req_yet", 32'(mem_req_o), 32'h0);
        ldr_addr_i = 22'h000777; ldr_d_i = 8'h11;
        cpu_a_i = 16'h6000; ram_ce_n_i = 1'b0; cpu_rd_n_i = 1'b0;
        tick();
        ldr_wr_i = 1'b0;
        chk("tie_ldr_req",  32'(mem_req_o),  32'h1);
        chk("tie_ldr_we",   32'(mem_we_o),   32'h1);
        chk("tie_ldr_addr", 32'(mem_addr_o), 32'h012345);
        chk("tie_ldr_d",    32'(mem_d_o),    32'hAB);
        chk("tie_cpu_wait", 32'(cpu_wait_n_o), 32'h0);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("ldr_busy_clr", 32'(ldr_busy_o), 32'h0);
        chk("ldr_req_off",  32'(mem_req_o),  32'h0);
        tick();
        chk("ram_req",  32'(mem_req_o),  32'h1);
        chk("ram_addr", 32'(mem_addr_o), 32'h106000);
        chk("ram_we",   32'(mem_we_o),   32'h0);
        mem_ack_i = 1'b1; mem_d_i = 8'h3C;
        tick();
        mem_ack_i = 1'b0;
        chk("ram_rdata",   32'(cpu_d_o),      32'h3C);
        chk("ram_release", 32'(cpu_wait_n_o), 32'h1);
        tick();
        chk("ldr_dropped_no_req", 32'(mem_req_o),  32'h0);
        chk("ldr_dropped_busy",   32'(ldr_busy_o), 32'h0);
        bus_idle();
        tick();

`ifdef CV_MEM_ARB_WDOG_EN
        // Unacknowledged read times out after TIMEOUT cycles
        cpu_a_i = 16'h0010; ram_ce_n_i = 1'b0; cpu_rd_n_i = 1'b0;
        tick();
        chk("wd_req", 32'(mem_req_o), 32'h1);
        repeat (254) tick();
        chk("wd_err_before",  32'(err_o),        32'h0);
        chk("wd_wait_before", 32'(cpu_wait_n_o), 32'h0);
        tick();
        chk("wd_err",     32'(err_o),        32'h1);
        chk("wd_cpu_d",   32'(cpu_d_o),      32'hFF);
        chk("wd_release", 32'(cpu_wait_n_o), 32'h1);
        chk("wd_req_off", 32'(mem_req_o),    32'h0);
        bus_idle();
        tick();
        chk("wd_err_sticky", 32'(err_o), 32'h1);
`endif

        // Upper RAM write
        cpu_a_i = 16'h8001; upper_ram_ce_n_i = 1'b0; cpu_wr_n_i = 1'b0; cpu_d_i = 8'h42;
        tick();
        chk("uram_req",  32'(mem_req_o),  32'h1);
        chk("uram_we",   32'(mem_we_o),   32'h1);
        chk("uram_addr", 32'(mem_addr_o), 32'h108001);
        chk("uram_d",    32'(mem_d_o),    32'h42);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("uram_release", 32'(cpu_wait_n_o), 32'h1);
        chk("uram_we_off",  32'(mem_we_o),     32'h0);
        bus_idle();
        tick();

        // Reset mid-access, then a stray ack
        cpu_a_i = 16'h1234; ram_ce_n_i = 1'b0; cpu_rd_n_i = 1'b0;
        tick();
        chk("abort_req_on", 32'(mem_req_o), 32'h1);
        reset_n_i = 1'b0;
        bus_idle();
        tick();
        reset_n_i = 1'b1;
        chk("abort_req_off", 32'(mem_req_o), 32'h0);
        chk("abort_cpu_d",   32'(cpu_d_o),   32'hFF);
        chk("abort_err",     32'(err_o),     32'h0);
        mem_ack_i = 1'b1; mem_d_i = 8'h99;
        tick();
        mem_ack_i = 1'b0;
        chk("stray_ack_req",   32'(mem_req_o),    32'h0);
        chk("stray_ack_cpu_d", 32'(cpu_d_o),      32'hFF);
        chk("stray_ack_wait",  32'(cpu_wait_n_o), 32'h1);
        tick();
        chk("stray_ack_idle", 32'(mem_req_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
